// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller
// and the hazard logic that reuses its register-field definitions.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stage-register controls between the pipeline datapath
// (master) and the stall controller (slave).
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  ex_MemRead;
  logic [REG_ADDR_W-1:0] ex_write_reg;
  logic                  ex_branch_taken;
  logic                  mem_access;
  logic                  dmem_ready;

  logic                  dmem_req;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_en;
  logic                  idex_flush;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  memwb_bubble;
  logic                  mem_err;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_MemRead, ex_write_reg,
           ex_branch_taken, mem_access, dmem_ready,
    input  dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, memwb_bubble, mem_err, state_o, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_MemRead, ex_write_reg,
           ex_branch_taken, mem_access, dmem_ready,
    output dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, memwb_bubble, mem_err, state_o, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard: the ID instruction reads a register that the load in EX
// has not yet produced. $zero never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_i,
  output logic                  luh_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i & (id_rs_i == ex_write_reg_i);
  assign rt_hit = id_uses_rt_i & (id_rt_i == ex_write_reg_i);
  assign luh_o  = ex_mem_read_i & (ex_write_reg_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, branch
// squash, memory-wait freeze with timeout into a sticky error state.
//
// state | meaning
// RUN   | normal flow; load-use and branch handling active
// WAIT  | data memory access outstanding, upstream stages frozen
// ERR   | memory timeout; pipe frozen until reset
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stall_ctrl_if.slave   bus
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                luh;
  logic                mem_stall;
  logic                stall_evt;
  logic                timeout;

  logic dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_en, memwb_bubble;

  load_use_detect u_load_use_detect (
    .id_rs_i        (bus.id_rs),
    .id_rt_i        (bus.id_rt),
    .id_uses_rs_i   (bus.id_uses_rs),
    .id_uses_rt_i   (bus.id_uses_rt),
    .ex_mem_read_i  (bus.ex_MemRead),
    .ex_write_reg_i (bus.ex_write_reg),
    .luh_o          (luh)
  );

  assign mem_stall = (state_q != ERR) & bus.mem_access & ~bus.dmem_ready;
  assign timeout   = mem_stall & (wait_cnt_q == WAIT_LAST);
  // A squashed ID instruction cannot cause a load-use stall.
  assign stall_evt = (state_q != ERR) & (mem_stall | (luh & ~bus.ex_branch_taken));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (timeout)        state_d = ERR;
        else if (mem_stall) state_d = WAIT;
      end
      WAIT: begin
        if (!mem_stall)     state_d = RUN;
        else if (timeout)   state_d = ERR;
      end
      ERR:                  state_d = ERR;
      default:              state_d = RUN;
    endcase
  end

  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    memwb_bubble = 1'b0;
    // Everything is forced low while reset is held, abandoning any access.
    if (reset) begin
      dmem_req = bus.mem_access & (state_q != ERR);
      if (state_q == ERR) begin
        memwb_bubble = 1'b1;
      end else if (mem_stall) begin
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (luh) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d  = mem_stall ? wait_cnt_q + 1'b1 : '0;
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.dmem_req     = dmem_req;
  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.mem_err      = reset & (state_q == ERR);
  assign bus.state_o      = state_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares on the falling edge.
module tb_pipe_stall_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble}
  localparam logic [7:0] C_ZERO = 8'b0000_0000;
  localparam logic [7:0] C_NORM = 8'b1101_0110;
  localparam logic [7:0] C_MEMS = 8'b0000_0011;
  localparam logic [7:0] C_BR   = 8'b1111_1110;
  localparam logic [7:0] C_LUH  = 8'b0001_1110;
  localparam logic [7:0] C_ERR  = 8'b0000_0001;

  typedef struct {
    logic       req;
    logic [7:0] ctrl;
    logic [1:0] st;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t e;
  logic [7:0] act_ctrl;

  pipe_stall_ctrl_if #(.CNT_W(4)) bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic mr,
                      input logic [4:0] wreg, input logic br, input logic ma,
                      input logic rdy, input logic req, input logic [7:0] ctrl,
                      input logic [1:0] st, input int cnt, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    reset               = r;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rs      = urs;
    bus.id_uses_rt      = urt;
    bus.ex_MemRead      = mr;
    bus.ex_write_reg    = wreg;
    bus.ex_branch_taken = br;
    bus.mem_access      = ma;
    bus.dmem_ready      = rdy;
    x.req  = req;
    x.ctrl = ctrl;
    x.st   = st;
    x.cnt  = 4'(cnt);
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic idle(input logic [1:0] st, input int cnt, input string name);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, st, cnt, name);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act_ctrl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                  bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.memwb_bubble};
      tests++;
      if ({bus.dmem_req, act_ctrl} !== {e.req, e.ctrl}) begin
        fails++;
        $display("FAIL %s ctrl: got req=%b ctrl=%b, want req=%b ctrl=%b",
                 e.name, bus.dmem_req, act_ctrl, e.req, e.ctrl);
      end
      tests++;
      if ({bus.mem_err, bus.state_o} !== {(e.st == 2'd2), e.st}) begin
        fails++;
        $display("FAIL %s state: got err=%b state=%0d, want err=%b state=%0d",
                 e.name, bus.mem_err, bus.state_o, (e.st == 2'd2), e.st);
      end
      tests++;
      if (bus.stall_cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s stall_cnt: got %0d, want %0d", e.name, bus.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.ex_MemRead = 1'b0; bus.ex_write_reg = '0; bus.ex_branch_taken = 1'b0;
    bus.mem_access = 1'b0; bus.dmem_ready = 1'b0;

    // reset held with hazard and memory inputs active: outputs must stay 0
    step(0, 8, 0, 1, 0, 1, 8, 0, 1, 0, 0, C_ZERO, 0, 0, "reset_hold");
    // load-use
    step(1, 8, 0, 1, 0, 1, 8, 0, 0, 0, 0, C_LUH,  0, 0, "luh_rs");
    idle(0, 1, "luh_count");
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, C_NORM, 0, 1, "luh_zero_reg");
    step(1, 0, 9, 0, 1, 1, 9, 0, 0, 0, 0, C_LUH,  0, 1, "luh_rt");
    step(1, 10, 0, 0, 0, 1, 10, 0, 0, 0, 0, C_NORM, 0, 2, "luh_unused_rs");
    // branch squash overrides load-use
    step(1, 8, 0, 1, 0, 1, 8, 1, 0, 0, 0, C_BR,   0, 2, "branch_luh");
    idle(0, 2, "branch_nocount");
    // three-cycle memory wait, then ready
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 0, 2, "mwait1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 3, "mwait2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 4, "mwait3");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NORM, 1, 5, "mready");
    idle(0, 5, "mdone");
    // single-cycle access
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NORM, 0, 5, "single_acc");
    idle(0, 5, "single_done");
    // branch frozen behind memory wait, acted on after release
    step(1, 8, 0, 1, 0, 1, 8, 1, 1, 0, 1, C_MEMS, 0, 5, "br_frozen");
    step(1, 8, 0, 1, 0, 1, 8, 1, 1, 1, 1, C_BR,   1, 6, "br_release");
    idle(0, 6, "br_after");
    // timeout after 4 stall cycles
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 0, 6, "to1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 7, "to2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 8, "to3");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 9, "to4");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_ERR,  2, 10, "err_enter");
    step(1, 8, 0, 1, 0, 1, 8, 0, 1, 1, 0, C_ERR,  2, 10, "err_ready_luh");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ERR,  2, 10, "err_sticky");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 0, 0, "err_reset");
    idle(0, 0, "err_cleared");
    // asynchronous reset in the middle of a wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 0, 0, "rw1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_MEMS, 1, 1, "rw2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_ZERO, 0, 0, "rw_async_rst");
    idle(0, 0, "rw_released");
    // saturation of the 4-bit stall counter
    for (int k = 0; k < 20; k++) begin
      step(1, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0, C_LUH, 0, (k > 15) ? 15 : k, "sat_luh");
    end
    idle(0, 15, "sat_hold");

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
